// File: rtl/mac_pkg.sv
// Shared definitions for the streaming MAC: accumulator limit helpers,
// the saturating-add result record and the width legality rule.
package mac_pkg;

   localparam int MAX_ACC_W = 64;

   typedef struct packed {
      logic [MAX_ACC_W-1:0] sum;
      logic                 ovf;
   } sat_res_t;

   // Bit patterns of the accumulator limits, right-aligned in MAX_ACC_W bits.
   function automatic logic [MAX_ACC_W-1:0] MAX_S(input int w);
      return (64'd1 << (w - 1)) - 64'd1;
   endfunction

   function automatic logic [MAX_ACC_W-1:0] MIN_S(input int w);
      return 64'd1 << (w - 1);
   endfunction

   function automatic logic [MAX_ACC_W-1:0] MAX_U(input int w);
      return (w >= MAX_ACC_W) ? '1 : (64'd1 << w) - 64'd1;
   endfunction

   function automatic bit widths_legal(input int a_w, input int b_w, input int acc_w);
      return (acc_w >= a_w + b_w) && (acc_w <= MAX_ACC_W);
   endfunction

endpackage

// File: rtl/mac_sat_add.sv
// Combinational accumulator adder: acc + extended product, with overflow
// detection and optional clamping to the representable range.
module mac_sat_add
   import mac_pkg::*;
#(
   parameter int ACC_W    = 40,
   parameter int PROD_W   = 32,
   parameter bit SIGNED   = 1'b1,
   parameter bit SATURATE = 1'b1
) (
   input  logic [ACC_W-1:0]  acc,
   input  logic [PROD_W-1:0] prod,
   output logic [ACC_W-1:0]  sum,
   output logic              ovf
);

   localparam logic [MAX_ACC_W-1:0] MAX_S_V = MAX_S(ACC_W);
   localparam logic [MAX_ACC_W-1:0] MIN_S_V = MIN_S(ACC_W);
   localparam logic [MAX_ACC_W-1:0] MAX_U_V = MAX_U(ACC_W);

   logic [ACC_W:0] wide;
   sat_res_t       res;
   logic           unused_sum_bits;

   // One guard bit above the accumulator is enough to see any single-step overflow.
   function automatic sat_res_t clamp(input logic [ACC_W:0] s);
      sat_res_t r;
      r = '0;
      r.ovf = SIGNED ? (s[ACC_W] ^ s[ACC_W-1]) : s[ACC_W];
      r.sum[ACC_W-1:0] = s[ACC_W-1:0];
      if (r.ovf && SATURATE) begin
         if (!SIGNED)
            r.sum[ACC_W-1:0] = MAX_U_V[ACC_W-1:0];
         else if (s[ACC_W])
            r.sum[ACC_W-1:0] = MIN_S_V[ACC_W-1:0];
         else
            r.sum[ACC_W-1:0] = MAX_S_V[ACC_W-1:0];
      end
      return r;
   endfunction

   if (SIGNED) begin : g_signed
      logic signed [ACC_W:0] wide_s;
      assign wide_s = (ACC_W+1)'($signed(acc)) + (ACC_W+1)'($signed(prod));
      assign wide   = wide_s;
   end else begin : g_unsigned
      assign wide = (ACC_W+1)'(acc) + (ACC_W+1)'(prod);
   end

   assign res             = clamp(wide);
   assign sum             = res.sum[ACC_W-1:0];
   assign ovf             = res.ovf;
   assign unused_sum_bits = ^res.sum;

endmodule

// File: rtl/mac_stream_pipe.sv
// Pipelined streaming multiply-accumulate: operand register, product register,
// accumulate/output stage; one frame sum per in_last, with backpressure.
module mac_stream_pipe
   import mac_pkg::*;
#(
   parameter int A_W      = 16,
   parameter int B_W      = 16,
   parameter int ACC_W    = 40,
   parameter bit SIGNED   = 1'b1,
   parameter bit SATURATE = 1'b1,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [A_W-1:0]   in_a,
   input  logic [B_W-1:0]   in_b,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_data,
   output logic             out_overflow,
   output logic [CNT_W-1:0] out_count
);

   localparam int PROD_W = A_W + B_W;

   if (!widths_legal(A_W, B_W, ACC_W)) begin : g_bad_widths
      $error("mac_stream_pipe: ACC_W must be >= A_W+B_W and <= %0d", MAX_ACC_W);
   end

   logic              adv;
   logic              accept;
   logic              vld_p0, last_p0;
   logic [A_W-1:0]    a_p0;
   logic [B_W-1:0]    b_p0;
   logic [PROD_W-1:0] prod_c;
   logic              vld_p1, last_p1;
   logic [PROD_W-1:0] prod_p1;
   logic [ACC_W-1:0]  acc_p2;
   logic              ovf_p2;
   logic [CNT_W-1:0]  cnt_p2;
   logic [ACC_W-1:0]  sum_c;
   logic              sum_ovf_c;
   logic              ovf_next;
   logic [CNT_W-1:0]  cnt_next;

   function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   // A held result freezes every stage so nothing in flight is lost.
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv && !clear;
   assign accept   = in_valid && in_ready;

   // ---- p0: operand capture / p1: product ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_p0  <= 1'b0;
         last_p0 <= 1'b0;
         vld_p1  <= 1'b0;
         last_p1 <= 1'b0;
      end else if (clear) begin
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
      end else if (adv) begin
         vld_p0  <= accept;
         last_p0 <= accept && in_last;
         vld_p1  <= vld_p0;
         last_p1 <= last_p0;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         a_p0 <= in_a;
         b_p0 <= in_b;
      end
      if (adv && vld_p0)
         prod_p1 <= prod_c;
   end

   if (SIGNED) begin : g_smul
      logic signed [PROD_W-1:0] prod_s;
      assign prod_s = PROD_W'($signed(a_p0)) * PROD_W'($signed(b_p0));
      assign prod_c = prod_s;
   end else begin : g_umul
      assign prod_c = PROD_W'(a_p0) * PROD_W'(b_p0);
   end

   // ---- p2: accumulate and frame output ----
   mac_sat_add #(
      .ACC_W    (ACC_W),
      .PROD_W   (PROD_W),
      .SIGNED   (SIGNED),
      .SATURATE (SATURATE)
   ) u_sat_add (
      .acc  (acc_p2),
      .prod (prod_p1),
      .sum  (sum_c),
      .ovf  (sum_ovf_c)
   );

   assign ovf_next = ovf_p2 | sum_ovf_c;
   assign cnt_next = cnt_inc(cnt_p2);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_p2       <= '0;
         ovf_p2       <= 1'b0;
         cnt_p2       <= '0;
         out_valid    <= 1'b0;
         out_data     <= '0;
         out_overflow <= 1'b0;
         out_count    <= '0;
      end else if (clear) begin
         acc_p2    <= '0;
         ovf_p2    <= 1'b0;
         cnt_p2    <= '0;
         out_valid <= 1'b0;
      end else if (adv) begin
         out_valid <= vld_p1 && last_p1;
         if (vld_p1) begin
            if (last_p1) begin
               out_data     <= sum_c;
               out_overflow <= ovf_next;
               out_count    <= cnt_next;
               acc_p2       <= '0;
               ovf_p2       <= 1'b0;
               cnt_p2       <= '0;
            end else begin
               acc_p2 <= sum_c;
               ovf_p2 <= ovf_next;
               cnt_p2 <= cnt_next;
            end
         end
      end
   end

endmodule
